imm_gen_pipe: RTL
=================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 32, immediate width; only 32 and 64 are legal.
REQ-002 Parameter TAG_W, default 32, width of a sideband tag (PC, rd) carried with each immediate.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  producer offers an instruction this cycle.
REQ-006 in_ready  output  1  block can accept; transfer when in_valid && in_ready at a rising edge.
REQ-007 in_instr  input  25  instruction bits [31:7]; bit k of this port is instruction bit k+7.
REQ-008 in_immsrc  input  3  immediate format select.
REQ-009 in_tag  input  TAG_W  sideband, returned unchanged with its immediate.
REQ-010 flush  input  1  synchronous discard of all held and incoming entries.
REQ-011 out_valid  output  1  head entry available.
REQ-012 out_ready  input  1  consumer takes the head entry when out_valid && out_ready at a rising edge.
REQ-013 out_imm  output  XLEN  extended immediate of the head entry.
REQ-014 out_tag  output  TAG_W  tag of the head entry.
REQ-015 out_illegal  output  1  head entry had a reserved in_immsrc.

Function
REQ-016 Formats SHALL be decoded by in_immsrc, with s = instr[31] replicated to XLEN:
- 000 I: sext(instr[31:20]).
- 001 S: sext({instr[31:25], instr[11:7]}).
- 010 B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
- 011 J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
- 100 U: sext({instr[31:12], 12'b0}).
- 101 Z: zero-extended instr[19:15] (CSR zimm).
- 110 SHAMT: zero-extended instr[24:20] when XLEN=32, instr[25:20] when XLEN=64.
- 111: out_imm = 0 and out_illegal = 1.
REQ-017 Extension SHALL be computed at acceptance and stored with tag and illegal flag; outputs SHALL come from storage only, with no combinational input-to-output path.
REQ-018 Storage SHALL be a 2-entry in-order buffer; held count is 0, 1 or 2.
REQ-019 in_ready SHALL equal (count < 2) and SHALL depend only on registered state, not on out_ready.
REQ-020 Latency: an entry accepted at edge N into an empty buffer SHALL present out_valid = 1 after edge N; throughput is one entry per cycle when out_ready = 1 continuously.
REQ-021 Count transitions:
- push only: +1.
- pop only: -1.
- push and pop at count = 1: count stays 1, head advances to the new entry.
- push and pop at count = 0: not possible, since out_valid = 0.
REQ-022 While out_valid && !out_ready, out_imm, out_tag and out_illegal SHALL hold stable.
REQ-023 Entries SHALL leave in acceptance order; none SHALL be dropped or duplicated.
REQ-024 flush = 1 at edge N SHALL set count to 0 after edge N, discarding any entry offered or popped that cycle; flush overrides push and pop.
REQ-025 in_ready SHALL be 1 in the cycle after a flush.
REQ-026 out_illegal SHALL never block flow; illegal entries are passed through like legal ones.

Reset
REQ-027 reset_n = 0 SHALL immediately, without waiting for clk, force count = 0, out_valid = 0, in_ready = 1, out_imm = 0, out_tag = 0, out_illegal = 0.
REQ-028 Reset asserted mid-transfer SHALL discard all held entries; the first edge after reset_n rises SHALL accept normally.

Verification
REQ-029 XLEN=32, out_ready=1, in_instr=0xFFF00093>>7 (addi x1,x0,-1), in_immsrc=000 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_illegal=0.
REQ-030 Back-to-back, one per cycle:
- B 0xFE000EE3 -> out_imm 0xFFFFFFFC.
- J 0x0080006F -> out_imm 0x00000008.
- U 0x12345037 -> out_imm 0x12345000.
- Z, instr[19:15]=0x1F -> out_imm 0x0000001F.
- All four on consecutive cycles with matching tags.
REQ-031 XLEN=64:
- U 0x80000037 -> out_imm 0xFFFFFFFF80000000.
- SHAMT, instr[25:20]=0x3F -> out_imm 0x3F.
REQ-032 out_ready=0 with three pushes, tags 1,2,3:
- in_ready drops after the second push; tag 3 is held off.
- out_tag holds 1 while stalled.
- after out_ready=1, tags emerge in order 1,2,3.
REQ-033 Buffer full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, and no flushed or incoming entry ever appears.
REQ-034 Corner cases:
- in_immsrc=111 -> out_imm=0, out_illegal=1.
- reset_n pulsed low between edges while count=2 -> out_valid=0 immediately, with no clock edge.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate extender with a 2-entry in-order output buffer.
// Immediates are extended at acceptance; outputs come from registers only.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [24:0]      in_instr,
    input  logic [2:0]       in_immsrc,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             ill;
    } ent_t;

    logic [31:7] ins;
    logic [31:0] raw;
    logic        ill;
    ent_t        new_ent;

    assign ins = in_instr;

    // Every format is built as a 32-bit value whose top bit is the sign;
    // zero-extended formats keep bit 31 clear, so one sign-extension serves all.
    always_comb begin
        raw = '0;
        ill = 1'b0;
        unique case (in_immsrc)
            3'b000: raw = {{20{ins[31]}}, ins[31:20]};
            3'b001: raw = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            3'b010: raw = {{19{ins[31]}}, ins[31], ins[7],
                           ins[30:25], ins[11:8], 1'b0};
            3'b011: raw = {{11{ins[31]}}, ins[31], ins[19:12],
                           ins[20], ins[30:21], 1'b0};
            3'b100: raw = {ins[31:12], 12'b0};
            3'b101: raw = {27'b0, ins[19:15]};
            3'b110: begin
                if (XLEN == 64) raw = {26'b0, ins[25:20]};
                else            raw = {27'b0, ins[24:20]};
            end
            3'b111: ill = 1'b1;
        endcase
    end

    assign new_ent.imm = XLEN'($signed(raw));
    assign new_ent.tag = in_tag;
    assign new_ent.ill = ill;

    logic [1:0] cnt_q, cnt_d;
    ent_t       hd_q, hd_d;
    ent_t       tl_q, tl_d;
    logic       push, pop;

    assign in_ready  = (cnt_q != 2'd2);
    assign out_valid = (cnt_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        cnt_d = cnt_q;
        hd_d  = hd_q;
        tl_d  = tl_q;
        if (flush) begin
            cnt_d = 2'd0;
        end else begin
            unique case (1'b1)
                push && pop: begin
                    // only reachable at count 1: new entry becomes head
                    hd_d = new_ent;
                end
                push && !pop: begin
                    if (cnt_q == 2'd0) hd_d = new_ent;
                    else               tl_d = new_ent;
                    cnt_d = cnt_q + 2'd1;
                end
                !push && pop: begin
                    hd_d  = tl_q;
                    cnt_d = cnt_q - 2'd1;
                end
                !push && !pop: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 2'd0;
            hd_q  <= '0;
            tl_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            hd_q  <= hd_d;
            tl_q  <= tl_d;
        end
    end

    assign out_imm     = hd_q.imm;
    assign out_tag     = hd_q.tag;
    assign out_illegal = hd_q.ill;

endmodule
